fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline. Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. Handles hazard-unit stalls, branch/jump redirects with flush, and a sticky halt on an out-of-range PC. Sits directly upstream of the instruction memory and decode stage.

---
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 108 ++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction fetch and IF/ID pipeline register with stall, redirect and halt
module fetch_stage #(
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int IMEM_DEPTH = 256,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_instr,
  output logic                ifid_valid,
  output logic [PC_WIDTH-1:0] ifid_pc,
  output logic [PC_WIDTH-1:0] ifid_pc_plus1,
  output logic [31:0]         ifid_instr,
  output logic                fetch_fault,
  output logic [31:0]         fetch_count
);
  typedef enum logic {RUN, HALT} state_e;
  localparam logic [PC_WIDTH-1:0] LIMIT = PC_WIDTH'(IMEM_DEPTH);
  state_e state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, ifid_pc_plus1_q, ifid_pc_plus1_d;
  logic [31:0] ifid_instr_q, ifid_instr_d, fetch_count_q, fetch_count_d;
  logic ifid_valid_q, ifid_valid_d, oob;
  assign oob = pc_q >= LIMIT;
  assign imem_addr = pc_q;
  assign ifid_valid = ifid_valid_q;
  assign ifid_pc = ifid_pc_q;
  assign ifid_pc_plus1 = ifid_pc_plus1_q;
  assign ifid_instr = ifid_instr_q;
  assign fetch_count = fetch_count_q;
  assign fetch_fault = state_q == HALT;
  // Next state: redirect beats the range check, which beats stall; HALT freezes everything
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d = ifid_pc_q;
    ifid_pc_plus1_d = ifid_pc_plus1_q;
    ifid_instr_d = ifid_instr_q;
    fetch_count_d = fetch_count_q;
    if (state_q == RUN) begin
      if (redirect_valid || oob) begin
        state_d = redirect_valid ? RUN : HALT;
        pc_d = redirect_valid ? redirect_pc : pc_q;
        ifid_valid_d = 1'b0;
        ifid_pc_d = '0;
        ifid_pc_plus1_d = '0;
        ifid_instr_d = NOP_INSTR;
      end else if (!stall) begin
        pc_d = pc_q + 1'b1;
        ifid_valid_d = 1'b1;
        ifid_pc_d = pc_q;
        ifid_pc_plus1_d = pc_q + 1'b1;
        ifid_instr_d = imem_instr;
        fetch_count_d = fetch_count_q + 1'b1;
      end
    end
  end
  // Register all fetch state; reset overrides every input including HALT
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q <= '0;
      ifid_pc_plus1_q <= '0;
      ifid_instr_q <= NOP_INSTR;
      fetch_count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q <= ifid_pc_d;
      ifid_pc_plus1_q <= ifid_pc_plus1_d;
      ifid_instr_q <= ifid_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus scoreboard for the fetch stage
module tb_fetch_stage;
  logic clk = 0, reset = 1, stall = 0, redirect_valid = 0;
  logic [31:0] redirect_pc = 0, imem_addr, imem_instr, ifid_pc, ifid_pc_plus1, ifid_instr, fetch_count;
  logic ifid_valid, fetch_fault;
  logic [31:0] mem [256];
  int checks = 0, errors = 0;
  typedef struct {
    logic st;
    logic rv;
    logic [31:0] rpc;
    logic v;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic f;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
    .ifid_pc_plus1(ifid_pc_plus1), .ifid_instr(ifid_instr), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  always_comb imem_instr = imem_addr < 256 ? mem[imem_addr[7:0]] : 32'hDEADBEEF;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic vec_t mk(logic st, logic rv, logic [31:0] rpc, logic v, logic [31:0] pc, logic [31:0] addr, logic [31:0] cnt, logic f);
    return '{st, rv, rpc, v, pc, addr, cnt, f};
  endfunction
  task automatic check(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic compare();
    vec_t e;
    logic [31:0] p1;
    e = sb.pop_front();
    p1 = e.v ? e.pc + 1 : 32'd0;
    check("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.v});
    check("ifid_pc", ifid_pc, e.pc);
    check("ifid_pc_plus1", ifid_pc_plus1, p1);
    check("ifid_instr", ifid_instr, e.v ? mem[e.pc[7:0]] : 32'h00000013);
    check("imem_addr", imem_addr, e.addr);
    check("fetch_count", fetch_count, e.cnt);
    check("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.f});
  endtask
  task automatic drive(vec_t x);
    @(negedge clk);
    reset = 0;
    stall = x.st;
    redirect_valid = x.rv;
    redirect_pc = x.rpc;
    sb.push_back(x);
    @(posedge clk);
    #1 compare();
  endtask
  task automatic do_reset(logic st);
    @(negedge clk);
    reset = 1;
    stall = st;
    redirect_valid = 0;
    sb.push_back(mk(st, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 compare();
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {16'hA5C3, i[15:0]};
    mem[0] = 32'h00100093;
    mem[1] = 32'h00108113;
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 2, 2, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2, 3, 3, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 1, 2, 3, 3, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 4, 4, 0));
    for (int i = 4; i <= 8; i++) vecs.push_back(mk(0, 0, 0, 1, i, i + 1, i + 1, 0));
    vecs.push_back(mk(0, 1, 14, 0, 0, 14, 9, 0));
    vecs.push_back(mk(0, 0, 0, 1, 14, 15, 10, 0));
    vecs.push_back(mk(1, 1, 20, 0, 0, 20, 10, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 20, 10, 0));
    vecs.push_back(mk(0, 0, 0, 1, 20, 21, 11, 0));
    vecs.push_back(mk(0, 1, 250, 0, 0, 250, 11, 0));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 0, 1, 250 + i, 251 + i, 12 + i, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 256, 17, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 256, 17, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 256, 17, 1));
    do_reset(0);
    foreach (vecs[i]) drive(vecs[i]);
    do_reset(0);
    drive(mk(0, 1, 300, 0, 0, 300, 0, 0));
    drive(mk(0, 0, 0, 0, 0, 300, 0, 1));
    do_reset(0);
    drive(mk(0, 0, 0, 1, 0, 1, 1, 0));
    drive(mk(0, 0, 0, 1, 1, 2, 2, 0));
    drive(mk(1, 0, 0, 1, 1, 2, 2, 0));
    do_reset(1);
    drive(mk(0, 0, 0, 1, 0, 1, 1, 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
